usb4_clk_en_gen: RTL and testbench
==================================

USB4_CLK_EN_GEN -- requirements
Module: usb4_clk_en_gen

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent strobe channels (1..16).
REQ-002 Parameter ACC_W, default 32, phase-accumulator and increment width (8..48).
REQ-003 Parameter RST_HOLD, default 3, number of channel-0 strobes for which rst_out stays asserted (1..255).
REQ-004 Parameter CNT_W, default 32, width of the channel-0 strobe counter.
REQ-005 local_clk  in  1  single clock; all logic on its rising edge.
REQ-006 rst  in  1  reset, synchronous, active-low.
REQ-007 ch_en  in  NUM_CH  per-channel run enable.
REQ-008 cfg_valid  in  1  increment-write request.
REQ-009 cfg_ch  in  clog2(NUM_CH) (min 1)  target channel of the write.
REQ-010 cfg_inc  in  ACC_W  new increment; strobe rate = cfg_inc / 2^ACC_W per local_clk cycle.
REQ-011 cfg_ready  out  1  high when a write is accepted this cycle.
REQ-012 cfg_err  out  1  one-cycle pulse on an accepted write with cfg_ch >= NUM_CH.
REQ-013 sw_rst_req  in  1  single-cycle request to re-run the reset sequence.
REQ-014 strobe_o  out  NUM_CH  per-channel one-cycle clock-enable pulses.
REQ-015 rst_out  out  1  sequenced downstream reset, active-low.
REQ-016 ch0_cnt_o  out  CNT_W  free-running count of channel-0 strobes.

Function
REQ-017 Each channel SHALL hold acc[i] and inc[i]; when ch_en[i]=1, {carry, acc[i]} <= acc[i] + inc[i] each cycle; strobe_o[i] SHALL be the registered carry (one-cycle latency).
REQ-018 When ch_en[i]=0, acc[i] SHALL hold and strobe_o[i] SHALL be 0 on the next cycle.
REQ-019 inc[i]=0 SHALL never strobe; accumulator wrap is modulo 2^ACC_W with no saturation.
REQ-020 cfg_ready SHALL be 1 when no write is pending; a write is accepted when cfg_valid=1 and cfg_ready=1.
REQ-021 An accepted write with a valid cfg_ch SHALL be held pending; cfg_ready SHALL be 0 while pending.
REQ-022 A pending increment SHALL be applied in the cycle where the target channel produces a carry (phase-aligned), or in the next cycle if that channel has ch_en=0; acc is not cleared.
REQ-023 An accepted write with an invalid cfg_ch SHALL be dropped, pulse cfg_err, and leave cfg_ready at 1.
REQ-024 Reset sequencer FSM states: HOLD (rst_out=0, counter cleared), COUNT (rst_out=0, counts channel-0 strobes), RUN (rst_out=1).
REQ-025 HOLD -> COUNT on the first cycle after rst deasserts; COUNT -> RUN in the cycle after the RST_HOLD-th channel-0 strobe; COUNT stalls while ch_en[0]=0.
REQ-026 sw_rst_req in RUN SHALL take the FSM to HOLD (rst_out=0 next cycle); sw_rst_req in HOLD or COUNT SHALL restart the count from 0.
REQ-027 ch0_cnt_o SHALL increment on every strobe_o[0] pulse in all FSM states and wrap to 0 at 2^CNT_W.

Reset
REQ-028 While rst=0 at a clock edge: acc=0, inc=0, no pending write, strobe_o=0, cfg_ready=1, cfg_err=0, rst_out=0, ch0_cnt_o=0, FSM=HOLD.
REQ-029 Reset asserted mid-operation SHALL discard any pending write and restart the sequence as in REQ-025.

Structure
REQ-030 A shared package SHALL hold the FSM state enum (HOLD, COUNT, RUN) and the increment constants for the 9.697, 10, 19.394, 20, 40 GHz and 1 MHz rates relative to the 80 GHz local_clk.
REQ-031 One sub-module, usb4_phase_acc, SHALL implement a single channel (accumulator, pending increment, strobe register) and be instantiated NUM_CH times.

Verification
REQ-032 ACC_W=8, inc[0]=64, ch_en[0] raised at edge 0 -> strobe_o[0] high after edges 4, 8, 12, ...; period 4.
REQ-033 ACC_W=8, inc[1]=96 -> exactly 3 strobes per 8 cycles, repeating; no two strobes on consecutive cycles.
REQ-034 RST_HOLD=3, inc[0]=128 after reset -> rst_out rises in the cycle after the 3rd channel-0 strobe (edge 7); ch0_cnt_o=3.
REQ-035 Write inc 64 -> 128 on channel 0 mid-period -> cfg_ready low until the next carry; thereafter the period is 2; the earlier pulse spacing is unchanged.
REQ-036 cfg_ch=5 with NUM_CH=4 -> one cfg_err pulse, cfg_ready stays 1, no inc change; sw_rst_req in RUN -> rst_out=0 next cycle, high again after 3 more strobes.
REQ-037 rst driven low during COUNT with a write pending -> all outputs at their REQ-028 values, pending write lost.

Source files
------------

// File: rtl/usb4_clk_en_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : usb4_clk_en_gen_pkg
// Description : Shared reset-sequencer states and standard strobe increments.
// Revision    : 1.0 - initial release
// ============================================================================
package usb4_clk_en_gen_pkg;

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_COUNT = 2'd1,
        ST_RUN   = 2'd2
    } seq_state_t;

    // 32-bit increments for an 80 GHz local_clk: round(f / 80e9 * 2^32)
    localparam int          c_ref_w       = 32;
    localparam logic [31:0] c_inc_9g697   = 32'd520603723;
    localparam logic [31:0] c_inc_10g     = 32'd536870912;
    localparam logic [31:0] c_inc_19g394  = 32'd1041207447;
    localparam logic [31:0] c_inc_20g     = 32'd1073741824;
    localparam logic [31:0] c_inc_40g     = 32'd2147483648;
    localparam logic [31:0] c_inc_1m      = 32'd53687;

    function automatic logic [47:0] scale_inc(input logic [31:0] inc32, input int acc_w);
        logic [47:0] w_res;
        if (acc_w >= c_ref_w) begin
            w_res = 48'(inc32) << (acc_w - c_ref_w);
        end else begin
            w_res = 48'(inc32 >> (c_ref_w - acc_w));
        end
        return w_res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/usb4_phase_acc.sv
`default_nettype none
// ============================================================================
// Module      : usb4_phase_acc
// Description : One strobe channel: phase accumulator, phase-aligned pending
//               increment update and registered carry strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module usb4_phase_acc
    import usb4_clk_en_gen_pkg::*;
#(
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_wr,
    input  logic [ACC_W-1:0] i_wr_inc,
    output logic             o_strobe,
    output logic             o_pending
);

    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_inc;
    logic [ACC_W-1:0] r_pend_inc;
    logic             r_pend;
    logic             r_strobe;
    logic [ACC_W:0]   w_sum;
    logic             w_carry;
    logic             w_apply;

    assign w_sum   = {1'b0, r_acc} + {1'b0, r_inc};
    assign w_carry = i_en & w_sum[ACC_W];
    // Swap increments on the wrap so the pulse in flight keeps its spacing.
    assign w_apply = r_pend & (w_carry | ~i_en);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_acc      <= '0;
            r_inc      <= '0;
            r_pend_inc <= '0;
            r_pend     <= 1'b0;
            r_strobe   <= 1'b0;
        end else begin
            if (i_en) begin
                r_acc <= w_sum[ACC_W-1:0];
            end
            r_strobe <= w_carry;
            if (w_apply) begin
                r_inc  <= r_pend_inc;
                r_pend <= 1'b0;
            end else if (i_wr) begin
                r_pend_inc <= i_wr_inc;
                r_pend     <= 1'b1;
            end
        end
    end

    assign o_strobe  = r_strobe;
    assign o_pending = r_pend;

endmodule
`default_nettype wire

// File: rtl/usb4_clk_en_gen.sv
`default_nettype none
// ============================================================================
// Module      : usb4_clk_en_gen
// Description : Multi-channel fractional clock-enable generator with a
//               strobe-counted downstream reset sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module usb4_clk_en_gen
    import usb4_clk_en_gen_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int ACC_W    = 32,
    parameter int RST_HOLD = 3,
    parameter int CNT_W    = 32
) (
    input  logic                                        local_clk,
    input  logic                                        rst,
    input  logic [NUM_CH-1:0]                           ch_en,
    input  logic                                        cfg_valid,
    input  logic [$clog2(NUM_CH > 1 ? NUM_CH : 2)-1:0]  cfg_ch,
    input  logic [ACC_W-1:0]                            cfg_inc,
    output logic                                        cfg_ready,
    output logic                                        cfg_err,
    input  logic                                        sw_rst_req,
    output logic [NUM_CH-1:0]                           strobe_o,
    output logic                                        rst_out,
    output logic [CNT_W-1:0]                            ch0_cnt_o
);

    localparam int         CH_W        = $clog2(NUM_CH > 1 ? NUM_CH : 2);
    localparam logic [7:0] c_hold_last = 8'(RST_HOLD - 1);

    logic [NUM_CH-1:0] w_pending;
    logic [NUM_CH-1:0] w_wr;
    logic              w_accept;
    logic              w_ch_valid;
    logic              r_cfg_err;
    logic [CNT_W-1:0]  r_ch0_cnt;
    seq_state_t        r_state;
    logic [7:0]        r_hold_cnt;
    logic              r_rst_out;

    // One write in flight across all channels keeps the handshake trivial.
    assign cfg_ready  = ~|w_pending;
    assign w_accept   = cfg_valid & cfg_ready;
    assign w_ch_valid = (32'(cfg_ch) < 32'(NUM_CH));

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign w_wr[i] = w_accept & w_ch_valid & (cfg_ch == CH_W'(i));

        usb4_phase_acc #(
            .ACC_W (ACC_W)
        ) u_phase_acc (
            .clk       (local_clk),
            .rst       (rst),
            .i_en      (ch_en[i]),
            .i_wr      (w_wr[i]),
            .i_wr_inc  (cfg_inc),
            .o_strobe  (strobe_o[i]),
            .o_pending (w_pending[i])
        );
    end

    always_ff @(posedge local_clk) begin
        if (!rst) begin
            r_cfg_err <= 1'b0;
            r_ch0_cnt <= '0;
        end else begin
            r_cfg_err <= w_accept & ~w_ch_valid;
            if (strobe_o[0]) begin
                r_ch0_cnt <= r_ch0_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge local_clk) begin
        if (!rst) begin
            r_state    <= ST_HOLD;
            r_hold_cnt <= '0;
            r_rst_out  <= 1'b0;
        end else begin
            case (r_state)
                ST_HOLD: begin
                    r_state    <= ST_COUNT;
                    r_hold_cnt <= '0;
                    r_rst_out  <= 1'b0;
                end
                ST_COUNT: begin
                    if (sw_rst_req) begin
                        r_hold_cnt <= '0;
                    end else if (strobe_o[0]) begin
                        if (r_hold_cnt == c_hold_last) begin
                            r_state   <= ST_RUN;
                            r_rst_out <= 1'b1;
                        end else begin
                            r_hold_cnt <= r_hold_cnt + 8'd1;
                        end
                    end
                end
                ST_RUN: begin
                    if (sw_rst_req) begin
                        r_state   <= ST_HOLD;
                        r_rst_out <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= ST_HOLD;
                    r_rst_out <= 1'b0;
                end
            endcase
        end
    end

    assign cfg_err   = r_cfg_err;
    assign rst_out   = r_rst_out;
    assign ch0_cnt_o = r_ch0_cnt;

endmodule
`default_nettype wire

// File: tb/tb_usb4_clk_en_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_usb4_clk_en_gen
// Description : Self-checking bench: cycle model plus directed literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usb4_clk_en_gen;

    localparam int NUM_CH   = 3;
    localparam int ACC_W    = 8;
    localparam int RST_HOLD = 3;
    localparam int CNT_W    = 4;
    localparam int CH_W     = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NUM_CH-1:0] ch_en;
    logic              cfg_valid;
    logic [CH_W-1:0]   cfg_ch;
    logic [ACC_W-1:0]  cfg_inc;
    logic              cfg_ready;
    logic              cfg_err;
    logic              sw_rst_req;
    logic [NUM_CH-1:0] strobe_o;
    logic              rst_out;
    logic [CNT_W-1:0]  ch0_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    usb4_clk_en_gen #(
        .NUM_CH   (NUM_CH),
        .ACC_W    (ACC_W),
        .RST_HOLD (RST_HOLD),
        .CNT_W    (CNT_W)
    ) dut (
        .local_clk  (clk),
        .rst        (rst),
        .ch_en      (ch_en),
        .cfg_valid  (cfg_valid),
        .cfg_ch     (cfg_ch),
        .cfg_inc    (cfg_inc),
        .cfg_ready  (cfg_ready),
        .cfg_err    (cfg_err),
        .sw_rst_req (sw_rst_req),
        .strobe_o   (strobe_o),
        .rst_out    (rst_out),
        .ch0_cnt_o  (ch0_cnt_o)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase as an integer fraction of 2^ACC_W, sequence as strobes seen.
    int m_acc[NUM_CH];
    int m_inc[NUM_CH];
    int m_pinc[NUM_CH];
    bit m_pend[NUM_CH];
    bit m_stb[NUM_CH];
    bit m_err;
    int m_cnt;
    int m_phase;
    int m_seen;

    always @(posedge clk) begin
        bit            stb0_prev;
        bit            any_pend;
        int            s;
        logic [NUM_CH-1:0] exp_stb;
        stb0_prev = m_stb[0];
        any_pend  = 1'b0;
        for (int c = 0; c < NUM_CH; c++) any_pend |= m_pend[c];
        if (!rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                m_acc[c] = 0; m_inc[c] = 0; m_pinc[c] = 0; m_pend[c] = 0; m_stb[c] = 0;
            end
            m_err = 0; m_cnt = 0; m_phase = 0; m_seen = 0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (ch_en[c]) begin
                    s        = m_acc[c] + m_inc[c];
                    m_stb[c] = (s >= (1 << ACC_W));
                    m_acc[c] = s % (1 << ACC_W);
                end else begin
                    m_stb[c] = 0;
                end
                if (m_pend[c] && (m_stb[c] || !ch_en[c])) begin
                    m_inc[c]  = m_pinc[c];
                    m_pend[c] = 0;
                end
            end
            m_err = 0;
            if (cfg_valid && !any_pend) begin
                if (int'(cfg_ch) < NUM_CH) begin
                    m_pend[cfg_ch] = 1;
                    m_pinc[cfg_ch] = int'(cfg_inc);
                end else begin
                    m_err = 1;
                end
            end
            if (stb0_prev) m_cnt = (m_cnt + 1) % (1 << CNT_W);
            case (m_phase)
                0: begin m_phase = 1; m_seen = 0; end
                1: begin
                    if (sw_rst_req) m_seen = 0;
                    else if (stb0_prev) begin
                        m_seen++;
                        if (m_seen == RST_HOLD) m_phase = 2;
                    end
                end
                default: if (sw_rst_req) m_phase = 0;
            endcase
        end
        #1;
        any_pend = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            any_pend  |= m_pend[c];
            exp_stb[c] = m_stb[c];
        end
        check("model_strobe", strobe_o, exp_stb);
        check("model_ready", cfg_ready, !any_pend);
        check("model_err", cfg_err, m_err);
        check("model_rst_out", rst_out, m_phase == 2);
        check("model_ch0_cnt", ch0_cnt_o, m_cnt);
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int w;
        int cnt;
        int prev;
        int consec;
        rst = 1'b0; ch_en = '0; cfg_valid = 1'b0; cfg_ch = '0; cfg_inc = '0; sw_rst_req = 1'b0;
        tick(3);
        check("reset_strobe", strobe_o, 0);
        check("reset_ready", cfg_ready, 1);
        check("reset_rst_out", rst_out, 0);
        check("reset_cnt", ch0_cnt_o, 0);

        // Load inc 128 on channel 0 while disabled, then start it.
        rst = 1'b1; cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_inc = 8'd128;
        tick();
        cfg_valid = 1'b0;
        check("pend_ready_low", cfg_ready, 0);
        tick();
        check("disabled_apply_ready", cfg_ready, 1);
        ch_en[0] = 1'b1;
        for (int n = 1; n <= 7; n++) begin
            tick();
            check("seq_strobe0", strobe_o[0], (n % 2 == 0) ? 1 : 0);
            if (n == 6) check("seq_rst_out_before", rst_out, 0);
        end
        check("seq_rst_out_rise", rst_out, 1);
        check("seq_ch0_cnt", ch0_cnt_o, 3);

        // 128 -> 64 waits for the next wrap, then period 4.
        cfg_valid = 1'b1; cfg_inc = 8'd64;
        tick();
        cfg_valid = 1'b0;
        check("wr64_ready_low", cfg_ready, 0);
        w = 0;
        while (!cfg_ready && w < 8) begin tick(); w++; end
        check("wr64_wait", w, 2);
        cnt = 0;
        for (int n = 0; n < 16; n++) begin tick(); cnt += int'(strobe_o[0]); end
        check("period4_count", cnt, 4);

        // 64 -> 128 mid-period; the carry that applies it still fires on time.
        cfg_valid = 1'b1; cfg_inc = 8'd128;
        tick();
        cfg_valid = 1'b0;
        check("wr128_ready_low", cfg_ready, 0);
        w = 0;
        while (!cfg_ready && w < 8) begin tick(); w++; end
        check("wr128_wait", w, 3);
        check("wr128_apply_strobe", strobe_o[0], 1);
        cnt = 0;
        for (int n = 0; n < 16; n++) begin tick(); cnt += int'(strobe_o[0]); end
        check("period2_count", cnt, 8);

        // Channel 1 at 96/256, channel 2 enabled with zero increment.
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_inc = 8'd96;
        tick();
        cfg_valid = 1'b0;
        tick();
        ch_en[2:1] = 2'b11;
        cnt = 0; consec = 0; prev = 0; w = 0;
        for (int n = 0; n < 24; n++) begin
            tick();
            cnt += int'(strobe_o[1]);
            if (strobe_o[1] && prev != 0) consec++;
            prev = int'(strobe_o[1]);
            w += int'(strobe_o[2]);
        end
        check("ch1_strobes_24", cnt, 9);
        check("ch1_consecutive", consec, 0);
        check("ch2_zero_inc", w, 0);

        // Disabling channel 0 silences it on the next cycle.
        ch_en[0] = 1'b0;
        tick();
        check("ch0_disabled_a", strobe_o[0], 0);
        tick();
        check("ch0_disabled_b", strobe_o[0], 0);
        ch_en[0] = 1'b1;
        tick(3);

        // Channel index 3 does not exist (5 is not encodable on a 2-bit cfg_ch).
        cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_inc = 8'd77;
        tick();
        cfg_valid = 1'b0;
        check("bad_ch_err", cfg_err, 1);
        check("bad_ch_ready", cfg_ready, 1);
        tick();
        check("bad_ch_err_pulse", cfg_err, 0);

        // Software reset from RUN.
        sw_rst_req = 1'b1;
        tick();
        sw_rst_req = 1'b0;
        check("swrst_rst_out", rst_out, 0);
        w = 0;
        while (!rst_out && w < 12) begin tick(); w++; end
        check("swrst_rerun", rst_out, 1);

        // Pending write on a never-wrapping channel, sw restart in COUNT, then hard reset.
        sw_rst_req = 1'b1;
        tick();
        sw_rst_req = 1'b0;
        tick();
        cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_inc = 8'd200;
        tick();
        cfg_valid = 1'b0;
        check("count_pend_ready", cfg_ready, 0);
        tick(2);
        sw_rst_req = 1'b1;
        tick();
        sw_rst_req = 1'b0;
        rst = 1'b0;
        tick(2);
        check("midrst_ready", cfg_ready, 1);
        check("midrst_strobe", strobe_o, 0);
        check("midrst_rst_out", rst_out, 0);
        check("midrst_cnt", ch0_cnt_o, 0);
        check("midrst_err", cfg_err, 0);

        // Counter wrap: 17 channel-0 strobes on a 4-bit counter.
        rst = 1'b1; ch_en = '0; cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_inc = 8'd128;
        tick();
        cfg_valid = 1'b0;
        tick();
        ch_en = 3'b111;
        tick(35);
        check("cnt_wrap", ch0_cnt_o, 1);
        check("ch2_lost_write", cfg_ready, 1);

        tick(4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
